usb_tx_pkt: RTL and testbench
=============================

// Module: usb_tx_pkt
// PURPOSE
//  USB device packet transmitter; the responder end of the transaction engine's TX packet interface.
//  Builds a packet from pkt_start/pkt_pid/pkt_len: PID byte, payload pulled from the EP buffer, CRC16.
//  Feeds bytes to the low-level serializer (SYNC, bit-stuff, NRZI, EOP) over a valid/ack stream.
//  Pulses pkt_done when the serializer reports EOP complete.
// PARAMETERS
//  LEN_W      10  width of pkt_len / payload byte counter (max payload 2^LEN_W-1)
//  PID_CHECK   1  1: a PID whose pid[1:0] is not 2'b11 (data group) is sent as PID only
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  pkt_start     in   1   one-cycle request, sampled in IDLE only
//  pkt_done      out  1   one-cycle pulse, packet fully on the wire
//  pkt_pid       in   4   PID, sampled with pkt_start
//  pkt_len       in   LEN_W payload length in bytes, sampled with pkt_start
//  pkt_data      in   8   payload byte, from buffer RAM with 1-cycle read latency
//  pkt_data_ack  out  1   current pkt_data consumed; requester advances its read address
//  ll_data       out  8   byte to serializer
//  ll_valid      out  1   ll_data valid
//  ll_last       out  1   ll_data is the final byte of the packet
//  ll_ack        in   1   serializer took ll_data this cycle; ignored unless ll_valid=1
//  ll_eop_done   in   1   serializer finished EOP for the last byte
// BEHAVIOUR
//  Reset: state=IDLE; pkt_done=0, pkt_data_ack=0, ll_valid=0, ll_last=0, ll_data=0, crc=16'hFFFF.
//  Reset mid-packet drops ll_valid at once (async). The serializer aborts itself; no done pulse.
//  FSM states: IDLE, PID, DATA, CRC_LO, CRC_HI, EOP.
//   IDLE: pkt_start=1 -> latch pid and len, crc<=FFFF, go to PID. The PID byte is on ll_data in the next cycle.
//   PID: ll_data={~pid,pid}, ll_valid=1. ll_last=1 if the packet is PID-only.
//        On ll_ack: PID-only -> EOP; len!=0 -> DATA; len==0 -> CRC_LO.
//   DATA: ll_data=pkt_data, pkt_data_ack=ll_ack (same cycle). On ack: crc updated with pkt_data, remaining-1.
//        On the ack where remaining==1 -> CRC_LO.
//   CRC_LO: ll_data=~crc[7:0]. On ack -> CRC_HI.
//   CRC_HI: ll_data=~crc[15:8], ll_last=1. On ack -> EOP.
//   EOP: ll_valid=0. On ll_eop_done -> pkt_done=1 for one cycle (registered), go to IDLE.
//  Data contract: pkt_data is valid from the cycle after pkt_start. It is valid again in the cycle after each ack.
//   Back-to-back ll_ack in DATA is legal: one byte per cycle.
//   pkt_data_ack is never asserted in the pkt_start cycle.
//  CRC16: polynomial x^16+x^15+x^2+1, LSB-first (reflected 0xA001), init FFFF, transmitted complemented, low byte first.
//  ll_valid stays high and ll_data stays stable until ll_ack (no withdrawal).
//  pkt_start outside IDLE is ignored (bench assertion flags it). ll_eop_done outside EOP is ignored.
//  ll_data/ll_last: combinational mux of the state and registered sources; no combinational path from ll_ack to ll_valid.
//  Latency: pkt_start -> first ll_valid = 1 cycle; ll_eop_done -> pkt_done = 1 cycle.
// STRUCTURE
//  usb_defs.vh (shared): PID_* constants, PID group masks, CRC16 polynomial/init/residual.
//  Sub-module usb_crc16_byte: combinational 8-bit-parallel CRC16 update (crc_in, data) -> crc_out.
//   The same sub-module serves a future RX CRC checker.
//  Top level: FSM, LEN_W-bit down-counter, PID/len latches, CRC register, output mux.
// TESTING
//  ACK: pid=4'h2 with ll_ack always 1 -> single byte 0xD2, ll_last=1, no pkt_data_ack; pkt_done 1 cycle after ll_eop_done.
//  ZLP: DATA1 pid=4'hB, len=0 -> bytes 4B 00 00; ll_last only on the 3rd byte; zero pkt_data_ack pulses.
//  Payload: DATA0, len=4, data 00 01 02 03, ll_ack continuous -> C3 00 01 02 03 + 2 CRC bytes matching the reference model.
//   Exactly 4 pkt_data_ack pulses.
//  Backpressure: same payload with random ll_ack gaps -> identical byte sequence; ll_data stable while valid and unacked.
//  Max length: len=1023 -> counter reaches 0 with no wrap; 1023 acks; CRC matches the model.
//  Abort/robustness: deassert rst_n during DATA -> ll_valid=0 at once, IDLE; next NAK (4'hA) gives 0x5A.
//   pkt_start while busy -> ignored.

Source files
------------

// File: rtl/usb_tx_pkt_pkg.sv
// Shared USB definitions: PID codes, PID group mask, CRC16 constants and
// transmitter FSM state codes.
package usb_tx_pkt_pkg;

   // Token PIDs
   localparam logic [3:0] PID_OUT   = 4'h1;
   localparam logic [3:0] PID_IN    = 4'h9;
   localparam logic [3:0] PID_SOF   = 4'h5;
   localparam logic [3:0] PID_SETUP = 4'hD;
   // Data PIDs
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [3:0] PID_DATA2 = 4'h7;
   localparam logic [3:0] PID_MDATA = 4'hF;
   // Handshake PIDs
   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;
   localparam logic [3:0] PID_NYET  = 4'h6;

   // pid[1:0] identifies the PID group; 2'b11 is the data group
   localparam logic [1:0] PID_GRP_DATA = 2'b11;

   // CRC16, reflected form (x^16+x^15+x^2+1), LSB-first
   localparam logic [15:0] CRC16_POLY     = 16'hA001;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

   // Transmitter FSM state codes
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PID    = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_CRC_LO = 3'd3;
   localparam logic [2:0] ST_CRC_HI = 3'd4;
   localparam logic [2:0] ST_EOP    = 3'd5;

   function automatic logic pid_is_data(input logic [3:0] pid);
      return pid[1:0] == PID_GRP_DATA;
   endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational 8-bit-parallel USB CRC16 update; shared by TX generation
// and RX checking.
module usb_crc16_byte
   import usb_tx_pkt_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   // Eight LSB-first shift steps of the reflected polynomial, unrolled
   always_comb begin
      c = crc_in ^ {8'h00, data};
      for (int unsigned i = 0; i < 8; i++) begin
         if (c[0]) c = (c >> 1) ^ CRC16_POLY;
         else      c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/usb_tx_pkt.sv
// USB device packet transmitter: PID byte, payload from the endpoint buffer,
// complemented CRC16, handed byte-wise to the serializer over valid/ack.
module usb_tx_pkt
   import usb_tx_pkt_pkg::*;
#(
   parameter int LEN_W     = 10,
   parameter int PID_CHECK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pkt_start,
   output logic             pkt_done,
   input  logic [3:0]       pkt_pid,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic [7:0]       pkt_data,
   output logic             pkt_data_ack,
   output logic [7:0]       ll_data,
   output logic             ll_valid,
   output logic             ll_last,
   input  logic             ll_ack,
   input  logic             ll_eop_done
);

   logic [2:0]       state;
   logic [3:0]       pid_q;
   logic [LEN_W-1:0] remaining;
   logic [15:0]      crc;
   logic [15:0]      crc_next;
   logic             pid_only;
   logic             take;

   assign pid_only = (PID_CHECK != 0) && !pid_is_data(pid_q);
   // Valid depends on state only, so reset removes it immediately
   assign ll_valid = (state == ST_PID) || (state == ST_DATA) ||
                     (state == ST_CRC_LO) || (state == ST_CRC_HI);
   assign take     = ll_valid && ll_ack;

   usb_crc16_byte u_crc (
      .crc_in  (crc),
      .data    (pkt_data),
      .crc_out (crc_next)
   );

   // Packet sequencing, length countdown, CRC accumulation, done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pid_q     <= '0;
         remaining <= '0;
         crc       <= CRC16_INIT;
         pkt_done  <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pkt_start) begin
                  pid_q     <= pkt_pid;
                  remaining <= pkt_len;
                  crc       <= CRC16_INIT;
                  state     <= ST_PID;
               end
            end
            ST_PID: begin
               if (take) begin
                  if (pid_only)               state <= ST_EOP;
                  else if (remaining != '0)   state <= ST_DATA;
                  else                        state <= ST_CRC_LO;
               end
            end
            ST_DATA: begin
               if (take) begin
                  crc       <= crc_next;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) state <= ST_CRC_LO;
               end
            end
            ST_CRC_LO: begin
               if (take) state <= ST_CRC_HI;
            end
            ST_CRC_HI: begin
               if (take) state <= ST_EOP;
            end
            ST_EOP: begin
               if (ll_eop_done) begin
                  pkt_done <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Output byte mux, last-byte flag and buffer-read acknowledge
   always_comb begin
      ll_data      = 8'h00;
      ll_last      = 1'b0;
      pkt_data_ack = 1'b0;
      case (state)
         ST_PID: begin
            ll_data = {~pid_q, pid_q};
            ll_last = pid_only;
         end
         ST_DATA: begin
            ll_data      = pkt_data;
            pkt_data_ack = ll_ack;
         end
         ST_CRC_LO: ll_data = ~crc[7:0];
         ST_CRC_HI: begin
            ll_data = ~crc[15:8];
            ll_last = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Self-checking bench for usb_tx_pkt: a buffer-RAM/serializer driver with
// random ack gaps, checked against a packet model built from the USB rules.
module tb_usb_tx_pkt;

   localparam int LEN_W = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pkt_start = 1'b0;
   logic             pkt_done;
   logic [3:0]       pkt_pid = '0;
   logic [LEN_W-1:0] pkt_len = '0;
   logic [7:0]       pkt_data = '0;
   logic             pkt_data_ack;
   logic [7:0]       ll_data;
   logic             ll_valid;
   logic             ll_last;
   logic             ll_ack = 1'b0;
   logic             ll_eop_done = 1'b0;

   always #5 clk = ~clk;

   usb_tx_pkt #(.LEN_W(LEN_W), .PID_CHECK(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pkt_start    (pkt_start),
      .pkt_done     (pkt_done),
      .pkt_pid      (pkt_pid),
      .pkt_len      (pkt_len),
      .pkt_data     (pkt_data),
      .pkt_data_ack (pkt_data_ack),
      .ll_data      (ll_data),
      .ll_valid     (ll_valid),
      .ll_last      (ll_last),
      .ll_ack       (ll_ack),
      .ll_eop_done  (ll_eop_done)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] buf_mem [0:1023];
   logic [7:0] got_bytes [$];
   bit         got_last  [$];
   logic [7:0] exp_bytes [$];

   int acks_seen, done_pulses, done_cycle, eop_cycle;
   int stable_err, align_err, valid_after_last;
   bit first_valid, start_ack;
   bit abort_valid_before, abort_valid_after;

   // Reference CRC: bit-serial division over the payload, LSB of each byte first
   function automatic logic [15:0] model_crc(input int len);
      logic [15:0] c;
      bit fb;
      c = 16'hFFFF;
      for (int n = 0; n < len; n++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ buf_mem[n][b];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      return c;
   endfunction

   // Expected wire bytes for one packet
   task automatic build_expected(input logic [3:0] pid, input int len);
      logic [15:0] c;
      exp_bytes.delete();
      exp_bytes.push_back({~pid, pid});
      if (pid[1:0] == 2'b11) begin
         for (int n = 0; n < len; n++) exp_bytes.push_back(buf_mem[n]);
         c = ~model_crc(len);
         exp_bytes.push_back(c[7:0]);
         exp_bytes.push_back(c[15:8]);
      end
   endtask

   // Drives one packet as buffer RAM + serializer and records what came out
   task automatic run_packet(input logic [3:0] pid, input int len, input int ack_pct,
                             input int poke_cycle, input int abort_cycle);
      int addr, eop_wait;
      bit pending, saw_last, eop_sent;
      logic [7:0] held;
      got_bytes.delete();
      got_last.delete();
      acks_seen = 0; done_pulses = 0; done_cycle = -1; eop_cycle = -1;
      stable_err = 0; align_err = 0; valid_after_last = 0;
      addr = 0; eop_wait = 0; pending = 0; saw_last = 0; eop_sent = 0; held = '0;
      @(posedge clk); #1;
      pkt_start = 1'b1; pkt_pid = pid; pkt_len = LEN_W'(len);
      ll_ack = 1'b1;
      #1;
      start_ack = pkt_data_ack;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(posedge clk); #1;
         pkt_start   = 1'b0;
         ll_eop_done = 1'b0;
         if (saw_last && !eop_sent) begin
            if (eop_wait == 0) begin
               ll_eop_done = 1'b1; eop_sent = 1; eop_cycle = cyc;
            end else eop_wait--;
         end
         if (cyc == poke_cycle) begin
            pkt_start = 1'b1; pkt_pid = 4'hA; pkt_len = LEN_W'(7);
            ll_eop_done = 1'b1;
         end
         pkt_data = buf_mem[addr % 1024];
         ll_ack   = ($urandom_range(99) < ack_pct);
         #1;
         if (cyc == abort_cycle) begin
            abort_valid_before = ll_valid;
            rst_n = 1'b0;
            #1;
            abort_valid_after = ll_valid;
            ll_ack = 1'b0; ll_eop_done = 1'b0;
            return;
         end
         if (cyc == 0) first_valid = ll_valid;
         if (pkt_done) begin
            done_pulses++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (pkt_data_ack) begin
            if (!(ll_valid && ll_ack)) align_err++;
            acks_seen++;
            addr++;
         end
         if (ll_valid) begin
            if (saw_last) valid_after_last++;
            if (pending && ll_data !== held) stable_err++;
            if (ll_ack) begin
               got_bytes.push_back(ll_data);
               got_last.push_back(ll_last);
               pending = 0;
               if (ll_last) begin
                  saw_last = 1;
                  eop_wait = $urandom_range(3);
               end
            end else begin
               pending = 1; held = ll_data;
            end
         end
         if (done_cycle >= 0 && cyc >= done_cycle + 2) break;
      end
      ll_ack = 1'b0; ll_eop_done = 1'b0; pkt_start = 1'b0;
   endtask

   // Compares captured packet against the model; tag names the scenario
   task automatic compare_packet(input string tag, input int len);
      int n;
      n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
      total++;
      if (got_bytes.size() !== exp_bytes.size()) begin
         bad++; $display("FAIL %s byte_count got=%0d exp=%0d", tag, got_bytes.size(), exp_bytes.size());
      end
      for (int i = 0; i < n; i++) begin
         total++;
         if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== (i == exp_bytes.size() - 1)) begin
            bad++;
            $display("FAIL %s byte[%0d] got=%02h/last=%0d exp=%02h/last=%0d", tag, i,
                     got_bytes[i], got_last[i], exp_bytes[i], i == exp_bytes.size() - 1);
         end
      end
      total++;
      if (acks_seen !== len) begin
         bad++; $display("FAIL %s data_ack_count got=%0d exp=%0d", tag, acks_seen, len);
      end
      total++;
      if (done_cycle !== eop_cycle + 1 || done_pulses !== 1) begin
         bad++; $display("FAIL %s pkt_done got_cycle=%0d pulses=%0d exp_cycle=%0d pulses=1",
                         tag, done_cycle, done_pulses, eop_cycle + 1);
      end
      total++;
      if (first_valid !== 1'b1 || start_ack !== 1'b0) begin
         bad++; $display("FAIL %s start_latency valid=%0d start_ack=%0d exp valid=1 start_ack=0",
                         tag, first_valid, start_ack);
      end
      total++;
      if (stable_err !== 0 || align_err !== 0 || valid_after_last !== 0) begin
         bad++; $display("FAIL %s handshake unstable=%0d misaligned_ack=%0d valid_after_last=%0d exp=0/0/0",
                         tag, stable_err, align_err, valid_after_last);
      end
   endtask

   task automatic test_reset();
      ll_ack = 1'b1; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ll_valid, ll_last, pkt_done, pkt_data_ack} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%04b exp=0000", {ll_valid, ll_last, pkt_done, pkt_data_ack});
      end
      total++;
      if (ll_data !== 8'h00) begin
         bad++; $display("FAIL reset_data got=%02h exp=00", ll_data);
      end
      ll_ack = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_ack();
      run_packet(4'h2, 0, 100, -1, -1);
      build_expected(4'h2, 0);
      compare_packet("ack", 0);
   endtask

   task automatic test_zlp();
      run_packet(4'hB, 0, 100, -1, -1);
      build_expected(4'hB, 0);
      compare_packet("zlp", 0);
   endtask

   task automatic test_payload();
      for (int i = 0; i < 4; i++) buf_mem[i] = 8'(i);
      run_packet(4'h3, 4, 100, -1, -1);
      build_expected(4'h3, 4);
      compare_packet("payload", 4);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) buf_mem[i] = 8'(i);
      run_packet(4'h3, 4, 40, -1, -1);
      build_expected(4'h3, 4);
      compare_packet("backpressure", 4);
   endtask

   task automatic test_random();
      logic [3:0] pid;
      int len;
      for (int k = 0; k < 8; k++) begin
         pid = 4'($urandom_range(15));
         len = $urandom_range(40);
         for (int i = 0; i < 1024; i++) buf_mem[i] = 8'($urandom);
         run_packet(pid, len, $urandom_range(100, 30), -1, -1);
         build_expected(pid, len);
         compare_packet("random", (pid[1:0] == 2'b11) ? len : 0);
      end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 1024; i++) buf_mem[i] = 8'($urandom);
      run_packet(4'h7, 1023, 90, -1, -1);
      build_expected(4'h7, 1023);
      compare_packet("max_len", 1023);
   endtask

   task automatic test_busy_start();
      for (int i = 0; i < 6; i++) buf_mem[i] = 8'($urandom);
      run_packet(4'hB, 6, 100, 3, -1);
      build_expected(4'hB, 6);
      compare_packet("busy_start", 6);
   endtask

   task automatic test_abort();
      for (int i = 0; i < 8; i++) buf_mem[i] = 8'($urandom);
      run_packet(4'h3, 8, 100, -1, 4);
      total++;
      if (abort_valid_before !== 1'b1 || abort_valid_after !== 1'b0) begin
         bad++; $display("FAIL abort_valid before=%0d after=%0d exp before=1 after=0",
                         abort_valid_before, abort_valid_after);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (pkt_done !== 1'b0 || ll_valid !== 1'b0) begin
         bad++; $display("FAIL abort_idle done=%0d valid=%0d exp 0/0", pkt_done, ll_valid);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_packet(4'hA, 0, 100, -1, -1);
      build_expected(4'hA, 0);
      compare_packet("nak_after_abort", 0);
   endtask

   initial begin
      test_reset();
      test_ack();
      test_zlp();
      test_payload();
      test_backpressure();
      test_random();
      test_max_len();
      test_busy_start();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
